// File: rtl/wmst_pkg.sv
// Shared types and helpers for the write-master burst controller.
package wmst_pkg;

    // Controller states; IDLE must stay at encoding 0 so reset lands there.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_CONFIG = 3'd2,
        S_TRANS  = 3'd3,
        S_NEXT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Default datapath width and the matching address stride per word.
    localparam int DEF_DW         = 32;
    localparam int BYTES_PER_WORD = DEF_DW / 8;

    // Smaller of two lengths; callers truncate the result to their own width.
    function automatic logic [31:0] min_len(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/wmst_burst_ctrl.sv
// Write-master control: splits one store job into FIFO-gated Avalon bursts
// of at most MAX_BURST words, with abort support.
module wmst_burst_ctrl
    import wmst_pkg::*;
#(
    parameter int AW        = 32,
    parameter int LW        = 16,
    parameter int DW        = DEF_DW,
    parameter int MAX_BURST = 128,
    parameter int FLW       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          store_start,
    input  logic [AW-1:0] store_base,
    input  logic [LW-1:0] store_len,
    input  logic          abort,
    input  logic [FLW-1:0] fifo_level,
    input  logic          store_trans_done,
    output logic          store_trans_start,
    output logic [AW-1:0] param_waddr,
    output logic [LW-1:0] param_iolen,
    output logic          store_busy,
    output logic          store_done,
    output logic          store_aborted
);

    localparam int STRIDE = DW / 8;
    // Common width for the FIFO-level vs chunk comparison (both zero-extended).
    localparam int CW = (FLW > LW) ? FLW : LW;

    state_t        state, state_nxt;
    logic [AW-1:0] cur_addr;
    logic [LW-1:0] remain;
    logic [LW-1:0] chunk;
    logic [AW-1:0] step;
    logic [CW-1:0] level_ext, chunk_ext;
    logic          fifo_ready;
    logic          abort_pend;
    logic          abort_seen;

    assign chunk      = LW'(min_len(32'(remain), 32'(MAX_BURST)));
    assign step       = AW'(chunk) * AW'(STRIDE);
    assign level_ext  = CW'(fifo_level);
    assign chunk_ext  = CW'(chunk);
    assign fifo_ready = (level_ext >= chunk_ext);
    // Abort only counts while a job is in progress and not already finishing.
    assign abort_seen = abort && (state == S_WAIT || state == S_CONFIG ||
                                  state == S_TRANS || state == S_NEXT);

    // Next-state decode; an abort seen in NEXT also ends the job right away.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (store_start)
                    state_nxt = (store_len == '0) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (abort_seen || abort_pend)
                    state_nxt = S_DONE;
                else if (fifo_ready)
                    state_nxt = S_CONFIG;
            end
            S_CONFIG: state_nxt = S_TRANS;
            S_TRANS: begin
                if (store_trans_done)
                    state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if ((remain == chunk) || abort_pend || abort_seen)
                    state_nxt = S_DONE;
                else
                    state_nxt = S_WAIT;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register, abort latch and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            abort_pend        <= 1'b0;
            store_trans_start <= 1'b0;
            store_busy        <= 1'b0;
            store_done        <= 1'b0;
            store_aborted     <= 1'b0;
        end else begin
            state             <= state_nxt;
            store_trans_start <= (state == S_CONFIG);
            store_busy        <= (state_nxt != S_IDLE);
            store_done        <= (state_nxt == S_DONE);
            store_aborted     <= (state_nxt == S_DONE) && (abort_pend || abort_seen);
            if (state == S_DONE)
                abort_pend <= 1'b0;
            else if (abort_seen)
                abort_pend <= 1'b1;
        end
    end

    // Burst planner: job position, remaining words and the issued burst parameters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr    <= '0;
            remain      <= '0;
            param_waddr <= '0;
            param_iolen <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (store_start) begin
                        cur_addr <= store_base;
                        remain   <= store_len;
                    end
                end
                S_CONFIG: begin
                    param_waddr <= cur_addr;
                    param_iolen <= chunk;
                end
                S_NEXT: begin
                    cur_addr <= cur_addr + step;
                    remain   <= remain - chunk;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wmst_burst_ctrl.sv
// Directed bench for wmst_burst_ctrl with hand-computed burst expectations.
module tb_wmst_burst_ctrl;

    localparam int LIM = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        store_start;
    logic [31:0] store_base;
    logic [15:0] store_len;
    logic        abort;
    logic [9:0]  fifo_level;
    logic        store_trans_done;
    logic        store_trans_start;
    logic [31:0] param_waddr;
    logic [15:0] param_iolen;
    logic        store_busy;
    logic        store_done;
    logic        store_aborted;

    int n_tests = 0;
    int n_fail  = 0;

    wmst_burst_ctrl #(
        .AW(32), .LW(16), .DW(32), .MAX_BURST(128), .FLW(10)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .store_start      (store_start),
        .store_base       (store_base),
        .store_len        (store_len),
        .abort            (abort),
        .fifo_level       (fifo_level),
        .store_trans_done (store_trans_done),
        .store_trans_start(store_trans_start),
        .param_waddr      (param_waddr),
        .param_iolen      (param_iolen),
        .store_busy       (store_busy),
        .store_done       (store_done),
        .store_aborted    (store_aborted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({store_trans_start, store_busy, store_done, store_aborted,
                    param_waddr, param_iolen});
    endfunction

    task automatic start_job(input logic [31:0] b, input logic [15:0] l);
        store_base  = b;
        store_len   = l;
        store_start = 1'b1;
        @(negedge clk);
        store_start = 1'b0;
    endtask

    task automatic wait_start(input string tag, output int n);
        n = 0;
        while (!store_trans_start && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIM) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: no store_trans_start within %0d cycles", tag, LIM);
        end
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (!store_done && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIM) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: no store_done within %0d cycles", tag, LIM);
        end
    endtask

    // Wait for a burst, check its parameters and that the start pulse is one cycle wide.
    task automatic expect_burst(input string tag, input logic [31:0] addr,
                                input logic [15:0] len, output int n);
        wait_start(tag, n);
        check({tag, "_addr"}, 64'(param_waddr), 64'(addr));
        check({tag, "_len"}, 64'(param_iolen), 64'(len));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(store_trans_start), 64'd0);
    endtask

    task automatic pulse_done();
        store_trans_done = 1'b1;
        @(negedge clk);
        store_trans_done = 1'b0;
    endtask

    initial begin
        int  n;
        logic seen;
        rst_n            = 1'b0;
        store_start      = 1'b0;
        store_base       = '0;
        store_len        = '0;
        abort            = 1'b0;
        fifo_level       = '0;
        store_trans_done = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", outs(), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outs", outs(), 64'd0);

        // Three bursts of a 300-word job with a full FIFO.
        fifo_level = 10'd512;
        start_job(32'h1000, 16'd300);
        check("t1_busy", 64'(store_busy), 64'd1);
        wait_start("t1_b1", n);
        check("t1_b1_lat", 64'(n), 64'd2);
        check("t1_b1_addr", 64'(param_waddr), 64'h1000);
        check("t1_b1_len", 64'(param_iolen), 64'd128);
        pulse_done();
        check("t1_b1_pulse", 64'(store_trans_start), 64'd0);
        expect_burst("t1_b2", 32'h1200, 16'd128, n);
        pulse_done();
        wait_start("t1_b3", n);
        check("t1_gap", 64'(n), 64'd3);
        check("t1_b3_addr", 64'(param_waddr), 64'h1400);
        check("t1_b3_len", 64'(param_iolen), 64'd44);
        pulse_done();
        wait_done("t1_done", n);
        check("t1_done", 64'(store_done), 64'd1);
        check("t1_aborted", 64'(store_aborted), 64'd0);
        @(negedge clk);
        check("t1_end", 64'({store_done, store_busy}), 64'd0);

        // Zero-length job completes immediately with no burst.
        start_job(32'h500, 16'd0);
        check("t2_cyc1", 64'({store_done, store_busy, store_trans_start}), 64'b110);
        @(negedge clk);
        check("t2_cyc2", 64'({store_done, store_busy, store_trans_start}), 64'b000);

        // FIFO gating: held in WAIT until enough words; stray trans_done ignored.
        fifo_level = 10'd100;
        start_job(32'h2000, 16'd200);
        seen = 1'b0;
        store_trans_done = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (store_trans_start) seen = 1'b1;
        end
        store_trans_done = 1'b0;
        check("t3_hold", 64'({seen, store_busy}), 64'b01);
        fifo_level = 10'd128;
        wait_start("t3_b1", n);
        check("t3_lat", 64'(n), 64'd2);
        check("t3_b1_len", 64'(param_iolen), 64'd128);
        fifo_level = 10'd72;
        pulse_done();
        expect_burst("t3_b2", 32'h2200, 16'd72, n);
        pulse_done();
        wait_done("t3_done", n);
        check("t3_aborted", 64'(store_aborted), 64'd0);
        @(negedge clk);

        // Abort during TRANS: burst finishes, no second burst, aborted flag set.
        fifo_level = 10'd512;
        start_job(32'h3000, 16'd300);
        wait_start("t4_b1", n);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (2) @(negedge clk);
        pulse_done();
        seen = 1'b0;
        n = 0;
        while (!store_done && n < 10) begin
            if (store_trans_start) seen = 1'b1;
            @(negedge clk);
            n++;
        end
        check("t4_done", 64'(store_done), 64'd1);
        check("t4_aborted", 64'(store_aborted), 64'd1);
        check("t4_no_b2", 64'(seen), 64'd0);
        @(negedge clk);
        check("t4_idle", 64'(store_busy), 64'd0);

        // Abort while in WAIT: done on the very next cycle.
        fifo_level = 10'd0;
        start_job(32'h4000, 16'd50);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4w_done", 64'({store_done, store_aborted}), 64'b11);
        @(negedge clk);
        check("t4w_idle", 64'({store_done, store_busy}), 64'd0);

        // Address wrap; a mid-job start with new parameters is ignored.
        fifo_level = 10'd512;
        start_job(32'hFFFF_FF00, 16'd192);
        wait_start("t5_b1", n);
        check("t5_b1_addr", 64'(param_waddr), 64'hFFFF_FF00);
        store_base  = 32'h0000_8000;
        store_len   = 16'd7;
        store_start = 1'b1;
        @(negedge clk);
        store_start = 1'b0;
        pulse_done();
        expect_burst("t5_b2", 32'h0000_0100, 16'd64, n);
        pulse_done();
        wait_done("t5_done", n);
        check("t5_aborted", 64'(store_aborted), 64'd0);
        @(negedge clk);
        check("t5_idle", 64'(store_busy), 64'd0);

        // Asynchronous reset in TRANS clears outputs at once; a fresh job then runs.
        start_job(32'h6000, 16'd300);
        wait_start("t6_b1", n);
        rst_n = 1'b0;
        #1;
        check("t6_rst_outs", outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_post_rst", outs(), 64'd0);
        start_job(32'h40, 16'd4);
        expect_burst("t6_b1", 32'h40, 16'd4, n);
        pulse_done();
        wait_done("t6_done", n);
        check("t6_aborted", 64'(store_aborted), 64'd0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
